// File: rtl/max_scan_ctrl.sv
`default_nettype none
// ============================================================================
// max_scan_ctrl -- start/busy/done sequencer that walks N consecutive BRAM
// addresses and reports the largest word and the offset of its first match.
// Optional: define MAX_SCAN_SIGNED_EN for a two's-complement compare.
// Revision: 1.0
// ============================================================================
module max_scan_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int N_W    = 8,
    parameter int RD_LAT = 1
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] startaddr,
    input  logic [N_W-1:0]    n,
    input  logic [DATA_W-1:0] douta,
    output logic [ADDR_W-1:0] addra,
    output logic              ena,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] max,
    output logic [N_W-1:0]    max_idx,
    output logic [N_W-1:0]    count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] c_addr_one  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [N_W-1:0]    c_cnt_one   = {{(N_W-1){1'b0}}, 1'b1};
    localparam logic [N_W:0]      c_issue_one = {{N_W{1'b0}}, 1'b1};

    logic [1:0]        state_q,  state_d;
    logic [N_W-1:0]    n_q,      n_d;
    logic [ADDR_W-1:0] addra_q,  addra_d;
    logic              ena_q,    ena_d;
    logic [N_W:0]      issue_q,  issue_d;
    logic [RD_LAT-1:0] vpipe_q,  vpipe_d;
    logic [DATA_W-1:0] max_q,    max_d;
    logic [N_W-1:0]    idx_q,    idx_d;
    logic [N_W-1:0]    count_q,  count_d;

    logic              w_tail;
    logic              w_gt;
    logic [N_W:0]      w_issue_inc;
    logic [N_W-1:0]    w_count_inc;

    // The tail of the enable shift register flags the cycle whose douta
    // belongs to a read this scan issued.
    generate
        if (RD_LAT == 1) begin : g_vpipe_lat1
            assign vpipe_d = ena_q;
        end else begin : g_vpipe_latn
            assign vpipe_d = {vpipe_q[RD_LAT-2:0], ena_q};
        end
    endgenerate

    assign w_tail      = vpipe_q[RD_LAT-1];
    assign w_issue_inc = issue_q + c_issue_one;
    assign w_count_inc = count_q + c_cnt_one;

`ifdef MAX_SCAN_SIGNED_EN
    assign w_gt = $signed(douta) > $signed(max_q);
`else
    assign w_gt = douta > max_q;
`endif

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        addra_d = addra_q;
        ena_d   = ena_q;
        issue_d = issue_q;
        max_d   = max_q;
        idx_d   = idx_q;
        count_d = count_q;

        // Strict compare keeps the lowest index on ties.
        if (w_tail) begin
            count_d = w_count_inc;
            if ((count_q == '0) || w_gt) begin
                max_d = douta;
                idx_d = count_q;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    n_d     = n;
                    addra_d = startaddr;
                    issue_d = '0;
                    count_d = '0;
                    max_d   = '0;
                    idx_d   = '0;
                    if (n != '0) begin
                        state_d = S_ISSUE;
                        ena_d   = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                addra_d = addra_q + c_addr_one;
                issue_d = w_issue_inc;
                if (w_issue_inc == {1'b0, n_q}) begin
                    ena_d   = 1'b0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_tail && (w_count_inc == n_q)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            addra_q <= '0;
            ena_q   <= 1'b0;
            issue_q <= '0;
            vpipe_q <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            addra_q <= addra_d;
            ena_q   <= ena_d;
            issue_q <= issue_d;
            vpipe_q <= vpipe_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    assign addra   = addra_q;
    assign ena     = ena_q;
    assign busy    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done    = (state_q == S_DONE);
    assign max     = max_q;
    assign max_idx = idx_q;
    assign count   = count_q;

endmodule
`default_nettype wire

// File: doc/max_scan_ctrl.md
Name: max_scan_ctrl

Overview:
- Sequencer for the max-search datapath: accepts a start command, walks N consecutive block-RAM addresses from a start address, compares returned words, and reports the maximum and its index with a done pulse.
- Sits between the top-level command logic (switches/UART/FSM) and the block RAM port A (addra/ena/douta).
- Replaces free-running count/limit/sreset sequencing with an explicit start/busy/done handshake.
- Models BRAM read latency with a valid pipeline.

Parameters:
- ADDR_W, 8, BRAM address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 16, BRAM data width.
- N_W, 8, width of the element-count input.
- RD_LAT, 1, BRAM read latency in cycles (legal 1..4).

Ports:
- mclk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  command strobe; sampled only when busy=0
- startaddr  in  ADDR_W  first address to scan; latched on accepted start
- n  in  N_W  number of words to scan; latched on accepted start
- douta  in  DATA_W  BRAM read data, valid RD_LAT cycles after addra/ena
- addra  out  ADDR_W  BRAM address (registered)
- ena  out  1  BRAM read enable (registered), high only while issuing
- busy  out  1  high from the cycle after accept until the last compare
- done  out  1  one-cycle pulse when the result is valid
- max  out  DATA_W  largest word found; held until next accepted start
- max_idx  out  N_W  offset (0..n-1) of the first occurrence of max
- count  out  N_W  number of words compared so far in the current scan

Behaviour:
- Reset (synchronous, active-high) forces state IDLE. On reset, outputs are: addra=0, ena=0, busy=0, done=0, max=0, max_idx=0, count=0. The valid pipeline is cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE/DONE with start=1: latch n; set addra<=startaddr, issue counter<=0, count<=0, max<=0, max_idx<=0.
  - n>0: go to ISSUE with ena<=1.
  - n=0: go directly to DONE; no reads are issued and max=0.
- ISSUE:
  - Each cycle addra<=addra+1 (wraps 2^ADDR_W-1 -> 0) and the issue counter increments.
  - After n addresses have been presented, set ena<=0 and go to DRAIN.
  - Exactly n enabled read cycles occur.
- Valid pipe: RD_LAT-deep shift register fed by ena. Its tail marks the cycle in which douta belongs to the current scan.
- Compare, on each valid-tail cycle:
  - First word (count=0): max<=douta, max_idx<=0 unconditionally.
  - Later words: update max and max_idx only if douta > max. The comparison is strict, so ties keep the lowest index.
  - count increments on every compare.
- DRAIN: exit to DONE on the cycle in which the n-th compare occurs.
- DONE: done=1 for exactly one cycle with busy=0. Without a new start, the next state is IDLE. A start in the DONE cycle is accepted as in IDLE.
- busy=1 in ISSUE and DRAIN only. start while busy=1 is ignored, with no effect on latched n, startaddr or results.
- Timing: start is sampled at edge E0. ena is high cycles 1..n. The n-th compare happens at the end of cycle n+RD_LAT. done is high in cycle n+RD_LAT+1.
- max, max_idx and count are stable from done until the next accepted start.
- Reset asserted mid-scan aborts immediately: outputs return to reset values, no done pulse, and in-flight reads are discarded.
- Maximum scan length is n=2^N_W-1. The issue counter is N_W+1 bits wide so it cannot alias.

Optional Feature:
- Macro MAX_SCAN_SIGNED_EN.
- Defined: douta and max are compared as two's-complement signed values.
- Undefined (default): unsigned compare.
- No other behaviour changes.

Test Plan:
- RAM[0x10..0x13]={5,9,3,9}, startaddr=0x10, n=4, RD_LAT=1 -> addra 0x10..0x13 with ena high cycles 1-4; done in cycle 6; max=9, max_idx=1, count=4.
- n=0, start=1 -> no ena cycles; done in cycle 1; max=0, max_idx=0, count=0.
- startaddr=0xFE, n=4, RAM{FE:2,FF:7,00:1,01:4} -> addra sequence FE,FF,00,01; max=7, max_idx=1.
- start pulsed again in cycle 2 of an n=4 scan with different startaddr/n -> ignored; result matches the original scan; single done pulse.
- reset asserted in cycle 3 of an n=8 scan -> next cycle all outputs 0, busy=0; no done; a following fresh start scans correctly.
- Data {0x0001, 0x8000}, n=2 -> without MAX_SCAN_SIGNED_EN max=0x8000, max_idx=1; with it max=0x0001, max_idx=0. Repeat the first scenario with RD_LAT=3: done in cycle 8, same result.
